rr_burst_scheduler: RTL and testbench

// - Shares one downstream resource (single beat channel) between N requesters.
// - Ownership is granted in round-robin order and held for a whole burst.
// - Release: last beat, MAX_BURST beats, requester stall timeout, or request withdrawn.
// - Wraps a rotating-priority pick with an ownership FSM, beat/stall counters and a valid/ready beat mux.

---
 rtl/rr_sched_pkg.sv | 15 +
 rtl/rr_pick.sv | 36 +++
 rtl/rr_burst_scheduler.sv | 131 +++++++++++++
 tb/tb_rr_burst_scheduler.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin burst scheduler.
package rr_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } sched_state_t;

  // Wrap-around increment of a requester index in a ring of n entries.
  function automatic int unsigned rr_next_ptr(input int unsigned sel, input int unsigned n);
    return (sel == n - 1) ? 32'd0 : sel + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority pick: first requester at or after i_ptr, wrapping around.
module rr_pick
  import rr_sched_pkg::*;
#(
  parameter int unsigned N = 10,
  parameter int unsigned M = 4
) (
  input  logic [N-1:0] i_req,
  input  logic [M-1:0] i_ptr,
  output logic [N-1:0] o_onehot,
  output logic [M-1:0] o_idx,
  output logic         o_any
);

  logic         found;
  logic [M-1:0] cand;

  // Scan ptr, ptr+1 .. N-1, 0 .. ptr-1 and keep the first set request.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = M'((32'(i_ptr) + k) % N);
      if (!found && i_req[cand]) begin
        found          = 1'b1;
        o_idx          = cand;
        o_onehot[cand] = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/rr_burst_scheduler.sv
// Round-robin owner of a single beat channel; ownership held for a burst.
module rr_burst_scheduler
  import rr_sched_pkg::*;
#(
  parameter  int unsigned N         = 10,
  parameter  int unsigned MAX_BURST = 8,
  parameter  int unsigned TIMEOUT   = 15,
  localparam int unsigned M         = (N > 1) ? $clog2(N) : 1
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_valid,
  input  logic [N-1:0] i_last,
  input  logic         i_res_ready,
  output logic [N-1:0] o_gnt,
  output logic [N-1:0] o_ready,
  output logic         o_res_valid,
  output logic [M-1:0] o_res_sel,
  output logic         o_res_last,
  output logic         o_busy,
  output logic         o_timeout
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  sched_state_t  state_q, state_d;
  logic [M-1:0]  ptr_q, ptr_d;
  logic [M-1:0]  sel_q, sel_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          tmo_q, tmo_d;

  logic [N-1:0]  pick_onehot;
  logic [M-1:0]  pick_idx;
  logic          pick_any;

  logic own, req_sel, valid_sel, res_valid, beat, cap_hit, last_hit, stall, tmo_hit;

  rr_pick #(
    .N (N),
    .M (M)
  ) u_pick (
    .i_req    (i_req),
    .i_ptr    (ptr_q),
    .o_onehot (pick_onehot),
    .o_idx    (pick_idx),
    .o_any    (pick_any)
  );

  assign own       = (state_q == S_OWN);
  assign req_sel   = i_req[sel_q];
  assign valid_sel = i_valid[sel_q];
  assign res_valid = own & req_sel & valid_sel;
  assign beat      = res_valid & i_res_ready;
  assign cap_hit   = (beat_q == BW'(MAX_BURST - 1));
  assign last_hit  = beat & (i_last[sel_q] | cap_hit);
  assign stall     = own & i_res_ready & ~valid_sel;
  assign tmo_hit   = (TIMEOUT != 0) && stall && (stall_q == SW'(TIMEOUT - 1));

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      beat_q  <= '0;
      stall_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
    end
  end

  // Ownership FSM: pick, hold for a burst, release, one turnaround cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (pick_any) begin
          state_d = S_OWN;
          sel_d   = pick_idx;
          gnt_d   = pick_onehot;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OWN: begin
        if (!req_sel || last_hit || tmo_hit) begin
          state_d = S_GAP;
          ptr_d   = M'(rr_next_ptr(32'(sel_q), N));
          sel_d   = '0;
          gnt_d   = '0;
          beat_d  = '0;
          stall_d = '0;
          tmo_d   = tmo_hit & req_sel & ~last_hit;
        end else if (beat) begin
          beat_d  = beat_q + BW'(1);
          stall_d = '0;
        end else if (stall && (TIMEOUT != 0)) begin
          stall_d = stall_q + SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_gnt       = gnt_q;
  assign o_ready     = gnt_q & {N{own & i_res_ready & req_sel}};
  assign o_res_valid = res_valid;
  assign o_res_sel   = sel_q;
  assign o_res_last  = res_valid & (i_last[sel_q] | cap_hit);
  assign o_busy      = own;
  assign o_timeout   = tmo_q;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Scenario bench for rr_burst_scheduler plus randomized run against a reference model.
module tb_rr_burst_scheduler;

  localparam int N         = 4;
  localparam int M         = 2;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 3;
  localparam int OW        = 2 * N + M + 4;

  logic         i_clk = 1'b0;
  logic         i_rstn;
  logic [N-1:0] i_req, i_valid, i_last;
  logic         i_res_ready;
  logic [N-1:0] o_gnt, o_ready;
  logic         o_res_valid;
  logic [M-1:0] o_res_sel;
  logic         o_res_last, o_busy, o_timeout;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: current owner (-1 when none), rotating pointer, counters.
  int m_owner;
  int m_ptr;
  int m_beats;
  int m_stalls;
  bit m_tmo;

  rr_burst_scheduler #(
    .N         (N),
    .MAX_BURST (MAX_BURST),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_req       (i_req),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .i_res_ready (i_res_ready),
    .o_gnt       (o_gnt),
    .o_ready     (o_ready),
    .o_res_valid (o_res_valid),
    .o_res_sel   (o_res_sel),
    .o_res_last  (o_res_last),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [OW-1:0] outs();
    return {o_gnt, o_ready, o_res_valid, o_res_sel, o_res_last, o_busy, o_timeout};
  endfunction

  function automatic void model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_beats  = 0;
    m_stalls = 0;
    m_tmo    = 1'b0;
  endfunction

  function automatic logic [OW-1:0] model_outs(input logic [N-1:0] req, input logic [N-1:0] valid,
                                               input logic [N-1:0] last, input logic rr);
    logic [N-1:0] g, r;
    logic [M-1:0] o;
    logic         v, l;
    g = '0; r = '0; o = '0; v = 1'b0; l = 1'b0;
    if (m_owner >= 0) begin
      o = M'(m_owner);
      g = N'(1) << o;
      v = req[o] && valid[o];
      r = (rr && req[o]) ? g : '0;
      l = v && (last[o] || (m_beats == MAX_BURST - 1));
    end
    return {g, r, v, o, l, (m_owner >= 0), m_tmo};
  endfunction

  function automatic void model_clock(input logic [N-1:0] req, input logic [N-1:0] valid,
                                      input logic [N-1:0] last, input logic rr);
    logic [M-1:0] o;
    bit beat, hit_last, hit_tmo;
    int st;
    m_tmo = 1'b0;
    if (m_owner >= 0) begin
      o        = M'(m_owner);
      beat     = req[o] && valid[o] && rr;
      hit_last = beat && (last[o] || (m_beats + 1 == MAX_BURST));
      st       = beat ? 0 : ((rr && !valid[o]) ? m_stalls + 1 : m_stalls);
      hit_tmo  = (TIMEOUT > 0) && (st == TIMEOUT);
      if (!req[o] || hit_last || hit_tmo) begin
        m_tmo    = hit_tmo && req[o] && !hit_last;
        m_ptr    = (m_owner + 1) % N;
        m_owner  = -1;
        m_beats  = 0;
        m_stalls = 0;
      end else begin
        m_beats  = m_beats + int'(beat);
        m_stalls = st;
      end
    end else if (|req) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && req[M'(c)]) m_owner = c;
      end
    end
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req       = '0;
    i_valid     = '0;
    i_last      = '0;
    i_res_ready = 1'b0;
  endtask

  task automatic apply_reset();
    i_rstn = 1'b0;
    idle_inputs();
    step();
    step();
    i_rstn = 1'b1;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    idle_inputs();
    step();
    vectors++;
    if (outs() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected all zero", outs());
    end
    step();
    i_rstn = 1'b1;
    i_req  = 4'b1010;
    #1;
    vectors++;
    if (o_gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL grant_latency: gnt %b expected 0000", o_gnt);
    end
    step();
    vectors++;
    if (o_gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL first_grant: gnt %b expected 0010", o_gnt);
    end
    vectors++;
    if (o_res_sel !== 2'd1) begin
      miscompares++;
      $display("FAIL first_sel: sel %0d expected 1", o_res_sel);
    end
    i_valid     = 4'b0010;
    i_res_ready = 1'b1;
    #1;
    vectors++;
    if (o_res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL beat_valid: res_valid %b expected 1", o_res_valid);
    end
    #2;
    i_rstn = 1'b0;
    #1;
    vectors++;
    if (outs() !== '0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got %b expected all zero", outs());
    end
    idle_inputs();
    step();
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g [9];
    exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    apply_reset();
    i_req       = 4'b1111;
    i_valid     = 4'b1111;
    i_last      = 4'b1111;
    i_res_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      vectors++;
      if ({o_gnt, o_ready, o_res_last} !== {exp_g[k], exp_g[k], (exp_g[k] != 4'b0000)}) begin
        miscompares++;
        $display("FAIL fairness step %0d: gnt/ready/last %b/%b/%b expected %b/%b/%b",
                 k, o_gnt, o_ready, o_res_last, exp_g[k], exp_g[k], (exp_g[k] != 4'b0000));
      end
    end
  endtask

  task automatic test_burst_cap();
    for (int v = 0; v < 2; v++) begin
      int beats;
      apply_reset();
      i_req       = (v == 1) ? 4'b0011 : 4'b0001;
      i_valid     = 4'b0001;
      i_last      = 4'b0000;
      i_res_ready = 1'b1;
      beats       = 0;
      step();
      for (int k = 1; k <= MAX_BURST; k++) begin
        vectors++;
        if (o_res_last !== (k == MAX_BURST)) begin
          miscompares++;
          $display("FAIL burst_last v%0d beat %0d: last %b expected %b", v, k, o_res_last, (k == MAX_BURST));
        end
        if (o_res_valid && i_res_ready) beats++;
        step();
      end
      vectors++;
      if (beats != MAX_BURST || o_gnt !== 4'b0000) begin
        miscompares++;
        $display("FAIL burst_cap v%0d: beats %0d gnt %b expected %0d beats gnt 0000", v, beats, o_gnt, MAX_BURST);
      end
      step();
      vectors++;
      if (o_gnt !== ((v == 1) ? 4'b0010 : 4'b0001)) begin
        miscompares++;
        $display("FAIL burst_next v%0d: gnt %b expected %b", v, o_gnt, (v == 1) ? 4'b0010 : 4'b0001);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    i_req = 4'b0100;
    step();
    i_req       = 4'b1101;
    i_valid     = 4'b0000;
    i_res_ready = 1'b1;
    for (int k = 0; k < TIMEOUT; k++) begin
      step();
      vectors++;
      if (k < TIMEOUT - 1) begin
        if ({o_gnt, o_timeout} !== {4'b0100, 1'b0}) begin
          miscompares++;
          $display("FAIL timeout_hold %0d: gnt %b timeout %b expected 0100 0", k, o_gnt, o_timeout);
        end
      end else if ({o_gnt, o_timeout, o_busy} !== {4'b0000, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL timeout_release: gnt %b timeout %b busy %b expected 0000 1 0", o_gnt, o_timeout, o_busy);
      end
    end
    step();
    vectors++;
    if ({o_gnt, o_timeout} !== {4'b1000, 1'b0}) begin
      miscompares++;
      $display("FAIL timeout_next: gnt %b timeout %b expected 1000 0", o_gnt, o_timeout);
    end
    // Withdrawal on the same cycle the stall limit is reached: no timeout pulse.
    apply_reset();
    i_req       = 4'b0100;
    i_res_ready = 1'b1;
    step();
    step();
    step();
    i_req = 4'b0000;
    step();
    vectors++;
    if ({o_gnt, o_timeout, o_busy} !== {4'b0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL timeout_not_sole: gnt %b timeout %b busy %b expected 0000 0 0", o_gnt, o_timeout, o_busy);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    i_req   = 4'b0010;
    i_valid = 4'b0010;
    step();
    i_res_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++;
      if ({o_gnt, o_timeout, o_ready} !== {4'b0010, 1'b0, 4'b0000}) begin
        miscompares++;
        $display("FAIL backpressure %0d: gnt %b timeout %b ready %b expected 0010 0 0000", k, o_gnt, o_timeout, o_ready);
      end
    end
    i_res_ready = 1'b1;
    #1;
    vectors++;
    if ({o_ready, o_res_valid} !== {4'b0010, 1'b1}) begin
      miscompares++;
      $display("FAIL bp_resume: ready %b res_valid %b expected 0010 1", o_ready, o_res_valid);
    end
    step();
    i_valid = 4'b0000;
    step();
    step();
    i_res_ready = 1'b0;
    for (int k = 0; k < 4; k++) step();
    vectors++;
    if ({o_gnt, o_timeout} !== {4'b0010, 1'b0}) begin
      miscompares++;
      $display("FAIL bp_stall_hold: gnt %b timeout %b expected 0010 0", o_gnt, o_timeout);
    end
    i_res_ready = 1'b1;
    step();
    vectors++;
    if ({o_gnt, o_timeout} !== {4'b0000, 1'b1}) begin
      miscompares++;
      $display("FAIL bp_stall_kept: gnt %b timeout %b expected 0000 1", o_gnt, o_timeout);
    end
  endtask

  task automatic test_withdraw_reset();
    apply_reset();
    i_req       = 4'b1000;
    i_valid     = 4'b1000;
    i_res_ready = 1'b1;
    step();
    step();
    step();
    vectors++;
    if (o_gnt !== 4'b1000) begin
      miscompares++;
      $display("FAIL withdraw_owner: gnt %b expected 1000", o_gnt);
    end
    i_req = 4'b0000;
    #1;
    vectors++;
    if (o_res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw_no_beat: res_valid %b expected 0", o_res_valid);
    end
    step();
    vectors++;
    if ({o_gnt, o_timeout, o_busy} !== {4'b0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL withdraw_gap: gnt %b timeout %b busy %b expected 0000 0 0", o_gnt, o_timeout, o_busy);
    end
    i_req = 4'b1010;
    step();
    vectors++;
    if (o_gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL withdraw_wrap: gnt %b expected 0010", o_gnt);
    end
    i_valid = 4'b0010;
    i_last  = 4'b0010;
    step();
    i_req   = 4'b1111;
    i_valid = 4'b0000;
    i_last  = 4'b0000;
    step();
    vectors++;
    if (o_gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL ptr_advance: gnt %b expected 0100", o_gnt);
    end
    i_valid = 4'b0100;
    #1;
    vectors++;
    if (o_res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_beat: res_valid %b expected 1", o_res_valid);
    end
    #2;
    i_rstn = 1'b0;
    #1;
    vectors++;
    if (outs() !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_beat: got %b expected all zero", outs());
    end
    i_valid = 4'b0000;
    step();
    step();
    i_rstn = 1'b1;
    step();
    vectors++;
    if (o_gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_ptr: gnt %b expected 0001", o_gnt);
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] exp_o;
    apply_reset();
    model_reset();
    i_req = 4'b1011;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) i_req = i_req ^ (N'(1) << b);
      i_valid     = N'($urandom);
      i_last      = N'($urandom) & N'($urandom);
      i_res_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_o = model_outs(i_req, i_valid, i_last, i_res_ready);
      vectors++;
      if (outs() !== exp_o) begin
        miscompares++;
        $display("FAIL random cycle %0d: gnt,ready,val,sel,last,busy,tmo got %b expected %b", c, outs(), exp_o);
      end
      @(posedge i_clk);
      model_clock(i_req, i_valid, i_last, i_res_ready);
      #1;
    end
  endtask

  initial begin
    i_rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_fairness();
    test_burst_cap();
    test_timeout();
    test_backpressure();
    test_withdraw_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
